// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg: shared definitions for the MIPS fetch stage.
// Holds the fetch FSM state encoding, the default reset PC, the AdEL
// exception code and small address helpers used by fetch_seq_ctrl.
package cpu_defs_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

  localparam logic [4:0] EXC_ADEL = 5'd4;

  // Branch/jump targets are word addresses when no address-error path exists.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  // Word aligned and inside [base, base+size); the limit is computed in 33 bits
  // so a window ending at 4 GiB does not wrap.
  function automatic logic addr_legal(input logic [31:0] a,
                                      input logic [31:0] base,
                                      input logic [31:0] size);
    logic [32:0] lim;
    lim = {1'b0, base} + {1'b0, size};
    return (a[1:0] == 2'b00) && (a >= base) && ({1'b0, a} < lim);
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: one-entry instruction buffer between fetch and ID.
// Loads {instr, pc, exc} on i_load, holds it until ID takes it
// (i_consume), then drops valid. Contents stay frozen while valid.
module fetch_buf
  import cpu_defs_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic        i_exc,
  input  logic        i_consume,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_exc
);

  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic        r_exc;

  // Load a new entry or retire the held one; data registers only move on load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_instr <= 32'h0;
      r_pc    <= RESET_PC;
      r_exc   <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_exc   <= i_exc;
    end else if (i_consume) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_exc   = r_exc;

endmodule

// File: rtl/fetch_seq_ctrl.sv
// fetch_seq_ctrl: fetch-stage sequencer for the pipelined MIPS core.
// Owns the fetch PC, requests words from a variable-latency instruction
// memory, and hands them to ID through a one-entry buffer. Taken branches
// from ID redirect the PC after the delay slot.
// Optional build macro FETCH_ADDR_CHECK_EN: checks each fetch address against
// the IMEM window, turns illegal fetches into AdEL buffer entries and halts
// fetching until the next redirect.
//
// state  | meaning
// S_IDLE | one cycle after reset; memory ack ignored
// S_REQ  | fetch of req_pc outstanding, waiting for imem_ack
// S_FULL | buffer holds an entry for ID, no request issued
// S_HALT | after an AdEL entry was consumed; waits for a redirect
module fetch_seq_ctrl
  import cpu_defs_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] IMEM_BASE = 32'h0000_3000,
  parameter logic [31:0] IMEM_SIZE = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  output logic        if_exc
);

  logic [1:0]  r_state;
  logic [1:0]  w_nxt_state;
  logic [31:0] r_req_pc;
  logic [31:0] w_nxt_req_pc;
  logic        r_pend_v;
  logic        w_nxt_pend_v;
  logic [31:0] r_pend_tgt;
  logic [31:0] w_nxt_pend_tgt;

  logic [31:0] w_redir_tgt;
  logic        w_load;
  logic [31:0] w_load_instr;
  logic        w_load_exc;
  logic        w_consume;
  logic        w_buf_valid;
  logic [31:0] w_buf_instr;
  logic [31:0] w_buf_pc;
  logic        w_buf_exc;

`ifdef FETCH_ADDR_CHECK_EN
  logic w_addr_ok;
  assign w_addr_ok   = addr_legal(r_req_pc, IMEM_BASE, IMEM_SIZE);
  assign w_redir_tgt = redirect_target;
  assign imem_req    = (r_state == S_REQ) && w_addr_ok;
  assign if_exc      = w_buf_exc;
`else
  // Window parameters and the buffer exc bit have no consumer in this build.
  logic w_unused_cfg;
  assign w_unused_cfg = ^{IMEM_BASE, IMEM_SIZE, w_buf_exc};
  assign w_redir_tgt  = word_align(redirect_target);
  assign imem_req     = (r_state == S_REQ);
  assign if_exc       = 1'b0;
`endif

  assign imem_addr = r_req_pc;
  assign w_consume = w_buf_valid & id_ready;

  // Next-state, next-PC and redirect bookkeeping for the fetch FSM.
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_req_pc   = r_req_pc;
    w_nxt_pend_v   = r_pend_v;
    w_nxt_pend_tgt = r_pend_tgt;
    w_load         = 1'b0;
    w_load_instr   = imem_rdata;
    w_load_exc     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_nxt_state = S_REQ;
      end
      S_REQ: begin
`ifdef FETCH_ADDR_CHECK_EN
        if (!w_addr_ok) begin
          // Illegal fetch never reaches memory; ID sees it as an AdEL entry.
          w_load       = 1'b1;
          w_load_instr = 32'h0;
          w_load_exc   = 1'b1;
          w_nxt_pend_v = 1'b0;
          w_nxt_state  = S_FULL;
        end else
`endif
        if (imem_ack) begin
          w_load = 1'b1;
          // A redirect arriving with the ack means the word just returned is
          // the delay slot, so the target goes straight into req_pc.
          if (redirect) begin
            w_nxt_req_pc = w_redir_tgt;
          end else if (r_pend_v) begin
            w_nxt_req_pc = r_pend_tgt;
          end else begin
            w_nxt_req_pc = r_req_pc + 32'd4;
          end
          w_nxt_pend_v = 1'b0;
          w_nxt_state  = S_FULL;
        end else if (redirect) begin
          // Delay slot still in flight: remember the target, keep the
          // request address stable for the memory.
          w_nxt_pend_v   = 1'b1;
          w_nxt_pend_tgt = w_redir_tgt;
        end
      end
      S_FULL: begin
        // Delay slot already buffered, req_pc is free to take the target.
        if (redirect) begin
          w_nxt_req_pc = w_redir_tgt;
        end
        if (id_ready) begin
`ifdef FETCH_ADDR_CHECK_EN
          w_nxt_state = w_buf_exc ? S_HALT : S_REQ;
`else
          w_nxt_state = S_REQ;
`endif
        end
      end
`ifdef FETCH_ADDR_CHECK_EN
      S_HALT: begin
        if (redirect) begin
          w_nxt_req_pc = w_redir_tgt;
          w_nxt_state  = S_REQ;
        end
      end
`endif
      default: begin
        w_nxt_state = S_IDLE;
      end
    endcase
  end

  // Fetch FSM state and PC registers; reset forces an immediate idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_req_pc   <= RESET_PC;
      r_pend_v   <= 1'b0;
      r_pend_tgt <= 32'h0;
    end else begin
      r_state    <= w_nxt_state;
      r_req_pc   <= w_nxt_req_pc;
      r_pend_v   <= w_nxt_pend_v;
      r_pend_tgt <= w_nxt_pend_tgt;
    end
  end

  fetch_buf #(
    .RESET_PC (RESET_PC)
  ) u_fetch_buf (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_instr   (w_load_instr),
    .i_pc      (r_req_pc),
    .i_exc     (w_load_exc),
    .i_consume (w_consume),
    .o_valid   (w_buf_valid),
    .o_instr   (w_buf_instr),
    .o_pc      (w_buf_pc),
    .o_exc     (w_buf_exc)
  );

  assign if_valid = w_buf_valid;
  assign if_instr = w_buf_instr;
  assign if_pc    = w_buf_pc;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// tb_fetch_seq_ctrl: directed bench for the fetch sequencer with a
// latency-programmable instruction memory model and a delivery monitor.
module tb_fetch_seq_ctrl;

`ifdef FETCH_ADDR_CHECK_EN
  localparam logic [31:0] TB_IMEM_SIZE = 32'h0000_2000;
`else
  localparam logic [31:0] TB_IMEM_SIZE = 32'h0000_1000;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        if_exc;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;
  int cnt;
  logic mem_en;
  logic [63:0] dq[$];

  fetch_seq_ctrl #(
    .RESET_PC  (32'h0000_3000),
    .IMEM_BASE (32'h0000_3000),
    .IMEM_SIZE (TB_IMEM_SIZE)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .if_valid        (if_valid),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .id_ready        (id_ready),
    .if_exc          (if_exc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // memory model: ack after 'lat' waiting cycles (0 = same cycle as req)
  always @(posedge clk) begin
    if (reset) cnt <= 0;
    else if (imem_req && !imem_ack) cnt <= cnt + 1;
    else cnt <= 0;
  end

  always @(posedge clk) begin
    #2;
    if (mem_en) begin
      imem_ack   = imem_req && (cnt >= lat);
      imem_rdata = instr_of(imem_addr);
    end
  end

  // delivery monitor
  always @(posedge clk) begin
    if (!reset && if_valid && id_ready) dq.push_back({if_pc, if_instr});
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect = 1'b0; redirect_target = 32'h0; id_ready = 1'b0;
    lat = 2; mem_en = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
    repeat (3) tick();
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b exp 0", imem_req); end
    n_tests++; if (imem_addr !== 32'h3000) begin n_fail++; $display("FAIL rst_addr got %h exp 3000", imem_addr); end
    n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", if_valid); end
    n_tests++; if (if_instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr got %h exp 0", if_instr); end
    n_tests++; if (if_pc !== 32'h3000) begin n_fail++; $display("FAIL rst_pc got %h exp 3000", if_pc); end
    n_tests++; if (if_exc !== 1'b0) begin n_fail++; $display("FAIL rst_exc got %b exp 0", if_exc); end
    reset = 1'b0;
    #1;
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_req got %b exp 0", imem_req); end
    tick();
    n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req got %b exp 1", imem_req); end
    n_tests++; if (imem_addr !== 32'h3000) begin n_fail++; $display("FAIL first_addr got %h exp 3000", imem_addr); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc[3];
    int n;
    exp_pc = '{32'h3000, 32'h3004, 32'h3008};
    dq.delete();
    id_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin
        n_fail++; $display("FAIL seq_wait_stable[%0d] got req=%b addr=%h exp req=1 addr=3000", k, imem_req, imem_addr);
      end
      tick();
    end
    n = 0;
    while (dq.size() < 3 && n < 50) begin tick(); n++; end
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (k >= dq.size()) begin
        n_fail++; $display("FAIL seq_deliver[%0d] got none exp pc %h", k, exp_pc[k]);
      end else if (dq[k] !== {exp_pc[k], instr_of(exp_pc[k])}) begin
        n_fail++; $display("FAIL seq_deliver[%0d] got %h exp %h", k, dq[k], {exp_pc[k], instr_of(exp_pc[k])});
      end
    end
    id_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int n;
    n = 0;
    while (!if_valid && n < 20) begin tick(); n++; end
    n_tests++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL bp_fill got valid=%b exp 1", if_valid); end
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (imem_req !== 1'b0 || if_pc !== 32'h300C || if_instr !== instr_of(32'h300C)) begin
        n_fail++; $display("FAIL bp_hold[%0d] got req=%b pc=%h instr=%h exp req=0 pc=300c instr=%h",
                           k, imem_req, if_pc, if_instr, instr_of(32'h300C));
      end
      tick();
    end
    dq.delete();
    id_ready = 1'b1;
    tick();
    n_tests++;
    if (dq.size() != 1 || dq[0][63:32] !== 32'h300C) begin
      n_fail++; $display("FAIL bp_release got count=%0d exp 1 entry pc 300c", dq.size());
    end
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h3010) begin
      n_fail++; $display("FAIL bp_resume got req=%b addr=%h exp req=1 addr=3010", imem_req, imem_addr);
    end
  endtask

  task automatic test_branch_inflight();
    logic [31:0] exp_a[3];
    logic [31:0] exp_b[2];
    int n;
    exp_a = '{32'h3010, 32'h3014, 32'h3100};
    exp_b = '{32'h3104, 32'h3180};
    dq.delete();
    n = 0;
    while (!(imem_req && imem_addr == 32'h3014) && n < 30) begin tick(); n++; end
    n_tests++; if (imem_addr !== 32'h3014) begin n_fail++; $display("FAIL br_slot_req got %h exp 3014", imem_addr); end
    redirect = 1'b1; redirect_target = 32'h3100;
    tick();
    redirect = 1'b0;
    n = 0;
    while (dq.size() < 3 && n < 60) begin tick(); n++; end
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (k >= dq.size()) begin
        n_fail++; $display("FAIL br_pend_order[%0d] got none exp %h", k, exp_a[k]);
      end else if (dq[k] !== {exp_a[k], instr_of(exp_a[k])}) begin
        n_fail++; $display("FAIL br_pend_order[%0d] got %h exp pc %h", k, dq[k], exp_a[k]);
      end
    end
    // redirect coincident with ack of the delay slot
    dq.delete();
    n = 0;
    while (!(imem_req && imem_addr == 32'h3104) && n < 30) begin tick(); n++; end
    n_tests++; if (imem_addr !== 32'h3104) begin n_fail++; $display("FAIL br_ack_slot got %h exp 3104", imem_addr); end
    lat = 0;
    redirect = 1'b1; redirect_target = 32'h3180;
    tick();
    redirect = 1'b0;
    n = 0;
    while (dq.size() < 2 && n < 40) begin tick(); n++; end
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (k >= dq.size()) begin
        n_fail++; $display("FAIL br_ack_order[%0d] got none exp %h", k, exp_b[k]);
      end else if (dq[k] !== {exp_b[k], instr_of(exp_b[k])}) begin
        n_fail++; $display("FAIL br_ack_order[%0d] got %h exp pc %h", k, dq[k], exp_b[k]);
      end
    end
  endtask

  task automatic test_branch_buffered();
    int n;
    id_ready = 1'b0;
    n = 0;
    while (!if_valid && n < 20) begin tick(); n++; end
    n_tests++; if (if_pc !== 32'h3184) begin n_fail++; $display("FAIL bb_slot_pc got %h exp 3184", if_pc); end
    redirect = 1'b1; redirect_target = 32'h3200;
    tick();
    redirect = 1'b0;
    n_tests++;
    if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h3184) begin
      n_fail++; $display("FAIL bb_hold got req=%b valid=%b pc=%h exp req=0 valid=1 pc=3184", imem_req, if_valid, if_pc);
    end
    id_ready = 1'b1;
    tick();
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h3200) begin
      n_fail++; $display("FAIL bb_target got req=%b addr=%h exp req=1 addr=3200", imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_midreq();
    int n;
    lat = 8;
    tick();
    tick();
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h3200) begin
      n_fail++; $display("FAIL mr_wait got req=%b addr=%h exp req=1 addr=3200", imem_req, imem_addr);
    end
    reset = 1'b1;
    #1;
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL mr_req_drop got %b exp 0", imem_req); end
    n_tests++; if (imem_addr !== 32'h3000) begin n_fail++; $display("FAIL mr_addr got %h exp 3000", imem_addr); end
    mem_en = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    tick();
    reset = 1'b0;
    tick();
    imem_ack = 1'b0;
    mem_en = 1'b1;
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h3000 || if_valid !== 1'b0) begin
      n_fail++; $display("FAIL mr_restart got req=%b addr=%h valid=%b exp req=1 addr=3000 valid=0", imem_req, imem_addr, if_valid);
    end
    lat = 0;
    dq.delete();
    n = 0;
    while (dq.size() < 1 && n < 20) begin tick(); n++; end
    n_tests++;
    if (dq.size() < 1) begin
      n_fail++; $display("FAIL mr_first got none exp pc 3000");
    end else if (dq[0] !== {32'h3000, instr_of(32'h3000)}) begin
      n_fail++; $display("FAIL mr_first got %h exp %h", dq[0], {32'h3000, instr_of(32'h3000)});
    end
  endtask

  task automatic test_addr_check();
    int n;
    id_ready = 1'b0;
    n = 0;
    while (!if_valid && n < 20) begin tick(); n++; end
    redirect = 1'b1; redirect_target = 32'h3102;
    tick();
    redirect = 1'b0;
    id_ready = 1'b1;
    tick();
`ifdef FETCH_ADDR_CHECK_EN
    n_tests++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h3102) begin
      n_fail++; $display("FAIL ac_noreq got req=%b addr=%h exp req=0 addr=3102", imem_req, imem_addr);
    end
    tick();
    n_tests++;
    if (if_valid !== 1'b1 || if_exc !== 1'b1 || if_pc !== 32'h3102 || if_instr !== 32'h0) begin
      n_fail++; $display("FAIL ac_entry got valid=%b exc=%b pc=%h instr=%h exp 1 1 3102 0", if_valid, if_exc, if_pc, if_instr);
    end
    tick();
    tick();
    n_tests++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
      n_fail++; $display("FAIL ac_halt got req=%b valid=%b exp 0 0", imem_req, if_valid);
    end
    redirect = 1'b1; redirect_target = 32'h4180;
    tick();
    redirect = 1'b0;
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4180) begin
      n_fail++; $display("FAIL ac_resume got req=%b addr=%h exp req=1 addr=4180", imem_req, imem_addr);
    end
    tick();
    n_tests++;
    if (if_valid !== 1'b1 || if_exc !== 1'b0 || if_pc !== 32'h4180) begin
      n_fail++; $display("FAIL ac_resume_entry got valid=%b exc=%b pc=%h exp 1 0 4180", if_valid, if_exc, if_pc);
    end
`else
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h3100) begin
      n_fail++; $display("FAIL ac_align got req=%b addr=%h exp req=1 addr=3100", imem_req, imem_addr);
    end
    tick();
    n_tests++;
    if (if_valid !== 1'b1 || if_exc !== 1'b0 || if_pc !== 32'h3100 || if_instr !== instr_of(32'h3100)) begin
      n_fail++; $display("FAIL ac_align_entry got valid=%b exc=%b pc=%h instr=%h exp 1 0 3100 %h",
                         if_valid, if_exc, if_pc, if_instr, instr_of(32'h3100));
    end
`endif
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_branch_inflight();
    test_branch_buffered();
    test_reset_midreq();
    test_addr_check();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
